mux_4x1_arbiter: RTL

MUX_4X1_ARBITER -- requirements
Module: mux_4x1_arbiter

---
 rtl/mux_4x1_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mux_4x1_arbiter.sv
// Four-requester round-robin arbiter with a registered BITS-wide 4:1 data mux.
// A grant is held while the owner keeps requesting. When another requester is
// waiting, the grant is handed over after MAX_HOLD captured samples. GNT/SEL
// come only from registers, so REQ has no combinational path to them.
module mux_4x1_arbiter #(
  parameter int BITS     = 4,
  parameter int MAX_HOLD = 4   // legal range 1..15
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [3:0]      REQ,
  input  logic [BITS-1:0] D3,
  input  logic [BITS-1:0] D2,
  input  logic [BITS-1:0] D1,
  input  logic [BITS-1:0] D0,
  output logic [3:0]      GNT,
  output logic [1:0]      SEL,
  output logic [BITS-1:0] DATA_OUT,
  output logic            VALID,
  output logic            BUSY
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

  state_t          state_reg, state_next;
  logic [1:0]      sel_reg, sel_next;
  logic [1:0]      last_reg, last_next;
  logic [3:0]      hold_reg, hold_next;
  logic [BITS-1:0] data_reg, data_next;
  logic            valid_reg, valid_next;

  logic [BITS-1:0] d_arr [4];
  logic [BITS-1:0] mux_out;
  logic [3:0]      sel_onehot;
  logic [3:0]      others;
  logic            others_any;
  logic [1:0]      rr_all;
  logic [1:0]      rr_oth;

  // Round-robin search starting just after 'last', wrapping ascending.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign d_arr[0] = D0;
  assign d_arr[1] = D1;
  assign d_arr[2] = D2;
  assign d_arr[3] = D3;

  // Data mux, request masking and round-robin winners for this cycle.
  always_comb begin
    mux_out    = d_arr[sel_reg];
    sel_onehot = 4'b0001 << sel_reg;
    others     = REQ & ~sel_onehot;
    others_any = |others;
    rr_all     = rr_pick(REQ, last_reg);
    rr_oth     = rr_pick(others, last_reg);
  end

  // State register plus the grant/hold/data registers; reset gives requester 0 first priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      last_reg  <= 2'd3;
      hold_reg  <= 4'd0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic: grant, capture, hold counting, rotation and handoff.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (|REQ) begin
          state_next = GRANT;
          sel_next   = rr_all;
          last_next  = rr_all;
          hold_next  = 4'd0;
        end
      end
      GRANT: begin
        if (REQ[sel_reg]) begin
          // Owner still requesting: always capture, then decide on rotation.
          data_next  = mux_out;
          valid_next = 1'b1;
          if (hold_reg == HOLD_LIMIT) begin
            hold_next = 4'd0;
            if (others_any) begin
              sel_next  = rr_oth;
              last_next = rr_oth;
            end
          end else begin
            hold_next = hold_reg + 4'd1;
          end
        end else begin
          // Owner released: DATA_OUT holds, hand off directly if anyone waits.
          valid_next = 1'b0;
          hold_next  = 4'd0;
          if (others_any) begin
            sel_next  = rr_oth;
            last_next = rr_oth;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: registered values straight out, BUSY from the state.
  always_comb begin
    BUSY     = (state_reg == GRANT);
    SEL      = sel_reg;
    DATA_OUT = data_reg;
    VALID    = valid_reg;
  end

  // One-hot grant, only while in GRANT.
  for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
    assign GNT[gi] = (state_reg == GRANT) && (sel_reg == 2'(gi));
  end

endmodule
